// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS-subset processor: sequences
// fetch/decode/execute/memory/write-back and drives every datapath control.
// Optional JAL support is enabled by defining MC_JAL_EN.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    reg_dst       = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // ALU speculatively forms the branch target while the opcode is decoded.
        alu_src_b = 2'b11;
        op_d      = opcode;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_J:             state_d = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:           state_d = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_SLTI) ? 2'b11 : 2'b00;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control state machine for the multi-cycle MIPS-subset processor. Each instruction runs as a sequence of states: fetch, decode, execute, memory and write-back. In every state the block drives the datapath multiplexer selects, the memory and register-file strobes, the PC/IR write enables and the 2-bit `alu_op` code consumed by the ALU controller. It sits between the instruction register (`opcode`), the ALU `zero` flag and the datapath.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset; forces state FETCH
- `opcode`  in  6  IR[31:26]; sampled only in DECODE
- `zero`  in  1  ALU zero flag; used only in BRANCH
- `pc_en`  out  1  PC load enable = `pc_write | (pc_write_cond & zero)`
- `pc_write`, `pc_write_cond`  out  1  unconditional / conditional PC write
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1  strobes
- `mem_to_reg`  out  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC
- `reg_dst`  out  2  destination register: 00 = rt, 01 = rd, 10 = $31
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A register
- `alu_src_b`  out  2  ALU B input: 00 = B register, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- `alu_op`  out  2  00 = add, 01 = sub, 10 = use funct field, 11 = slt
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `instr_done`  out  1  high during the final state of every instruction
- `illegal`  out  1  high in DECODE when the opcode is unsupported

## Operation
- All control outputs except `pc_en` and `illegal` are Moore outputs decoded from the registered state.
- Any output not listed for a state is 0.
- **FETCH:**
  - strobes: `mem_read`, `ir_write`, `pc_write`
  - selects: `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00
  - next: DECODE
- **DECODE:**
  - selects: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (computes the branch target)
  - next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000000 → R_EXEC
    - 000100 → BRANCH
    - 001000 (addi) → I_EXEC
    - 001010 (slti) → I_EXEC
    - 000010 → JUMP
    - 000011 → JAL (only with the macro)
    - any other opcode → FETCH, with `illegal`=1 for this cycle
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: lw → MEM_READ, sw → MEM_WRITE.
- **MEM_READ:** `mem_read`=1, `i_or_d`=1. Next: MEM_WB.
- **MEM_WB:** `reg_write`=1, `mem_to_reg`=01, `reg_dst`=00, `instr_done`=1. Next: FETCH.
- **MEM_WRITE:** `mem_write`=1, `i_or_d`=1, `instr_done`=1. Next: FETCH.
- **R_EXEC:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next: R_WB.
- **R_WB:** `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00, `instr_done`=1. Next: FETCH.
- **I_EXEC:** `alu_src_a`=1, `alu_src_b`=10. `alu_op`=00 for addi, 11 for slti. Next: I_WB.
- **I_WB:** `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00, `instr_done`=1. Next: FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Next: FETCH.
- **JUMP:** `pc_write`=1, `pc_source`=10, `instr_done`=1. Next: FETCH.
- Opcode handling:
  - The opcode is latched into a 6-bit register in DECODE.
  - MEM_ADDR and I_EXEC use this latched copy, so they are immune to IR changes.
  - The latched copy clears to 0 on reset.

## Timing
- Cycles per instruction, counted from entry to FETCH:
  - lw: 5
  - sw, R-type, addi, slti: 4
  - beq, j, jal: 3
  - illegal opcode: 2
- During and immediately after reset the state is FETCH, so the outputs take FETCH values:
  - `mem_read`=1, `ir_write`=1, `pc_write`=1, `pc_en`=1, `alu_src_b`=01
  - all other outputs 0
- Reset asserted mid-instruction: outputs return to FETCH values immediately (asynchronously); the in-flight instruction is abandoned.
- `pc_en` in BRANCH follows `zero` combinationally in the same cycle.
- `zero` is ignored in every other state.
- No stall input: every state lasts exactly one cycle.

## Configuration
- `MC_JAL_EN` defined:
  - Opcode 000011 decodes to the JAL state, which lasts 1 cycle.
  - In JAL: `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, `pc_write`=1, `pc_source`=10, `instr_done`=1.
  - The register file receives PC+4, the value already in PC after FETCH.
- `MC_JAL_EN` undefined:
  - The JAL state and 2-bit code value `reg_dst`=10 / `mem_to_reg`=10 are never produced.
  - Opcode 000011 takes the illegal path.

## Test plan
- Reset: assert `rst` mid-MEM_READ → outputs return to FETCH values in the same cycle; after release, the next edge enters DECODE.
- lw (opcode 100011): the state trace is FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB.
  - `instr_done` is high on cycle 5 only.
  - In MEM_WB, `mem_to_reg`=01.
- R-type then slti: `alu_op` is 10 in R_EXEC and 11 in I_EXEC.
  - R_WB has `reg_dst`=01.
  - I_WB has `reg_dst`=00.
- beq:
  - with `zero`=1 in BRANCH → `pc_en`=1, `pc_source`=01
  - with `zero`=0 → `pc_en`=0
  - in both cases the next state is FETCH
- Opcode 111111 → `illegal`=1 for exactly the DECODE cycle, then FETCH; no `reg_write` or `mem_write` is asserted.
- With `MC_JAL_EN`, opcode 000011 → the JAL cycle has `reg_dst`=10, `mem_to_reg`=10, `reg_write`=1, `pc_en`=1.
- Without `MC_JAL_EN`, opcode 000011 → `illegal`=1.
